muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative sequencer for the RV32M multiply/divide operations, sitting beside the ALU in the datapath. When the main controller asserts `start`, the block latches the operands and function, then runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop. It pulses `done` when `result` is valid. The main controller holds the instruction in execute until `done`, which drives its `exdone` input.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a new operation; sampled only in IDLE.
- `op`  in  3: funct3 of the M instruction. MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `rs1`  in  XLEN: multiplicand / dividend.
- `rs2`  in  XLEN: multiplier / divisor.
- `busy`  out  1: high from the cycle after acceptance through the cycle of `done`.
- `done`  out  1: one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  XLEN: registered result, held until the next accepted `start`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, `start`=1:
  - Latch `op`.
  - Latch the absolute values of the operands, treating each as signed or unsigned per `op`.
  - Latch the result sign flags.
  - Clear the iteration counter.
  - Go to MUL if `op[2]`=0, otherwise DIV.
- `start` outside IDLE is ignored. `op`, `rs1` and `rs2` are don't-care after the acceptance cycle.
- MUL: one partial-product add and shift per cycle into a 2·XLEN accumulator. Runs exactly XLEN cycles, then goes to FIX.
- DIV: one restoring subtract/shift per cycle producing a quotient bit. Runs exactly XLEN cycles, then goes to FIX.
- DIV special cases are resolved at acceptance and go directly to FIX, skipping iteration:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (`rs1`=most-negative, `rs2`=−1, DIV/REM): quotient = most-negative value, remainder = 0.
- FIX:
  - Apply two's-complement sign correction. Product sign = sign(a) XOR sign(b). Quotient sign = XOR of the operand signs. Remainder sign = sign of the dividend.
  - Select the output: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Write `result`, then go to DONE.
- DONE: `done`=1, `busy`=1, then go to IDLE unconditionally.
- Arithmetic is modulo 2·XLEN in the accumulator. For MULHSU, only `rs1` is treated as signed.

## Timing
- Cycle 0 is the edge that samples `start`=1 in IDLE.
- Normal operation: MUL/DIV in cycles 1..XLEN, FIX in cycle XLEN+1, `done` in cycle XLEN+2 (34 for XLEN=32).
- Special-case divide: FIX in cycle 1, `done` in cycle 2.
- A new `start` is accepted at the earliest in the cycle after `done`, so back-to-back throughput is one operation per XLEN+3 cycles.
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- `rst` asserted mid-operation aborts the operation:
  - State goes to IDLE on the next edge.
  - No `done` pulse is produced.
  - `result` is cleared.
- If `rst` and `start` are both high, reset wins and `start` is dropped.

## Configuration
- `RV_MULDIV_DIV_EN` defined: all eight ops are supported as above.
- `RV_MULDIV_DIV_EN` undefined:
  - The DIV state, divider datapath and special-case logic are removed.
  - Any op with `op[2]`=1 goes IDLE→DONE with `result`=0 and `done` in cycle 1.
  - Multiply timing is unchanged.

## Structure
- Shared package `riscv_pkg` holds:
  - the M-extension funct3 constants (`MULDIV_MUL` … `MULDIV_REMU`);
  - the `muldiv_state_t` enum;
  - `XLEN`.
- One sub-module, `muldiv_step`: combinational single-iteration add-or-subtract/shift slice, shared by the MUL and DIV loops.
- The FSM, counter and sign fix-up stay in `muldiv_seq`.

## Test plan
- MUL, `rs1`=7, `rs2`=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` exactly 34 cycles after `start`.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9÷2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100÷7 → 14. REMU 100÷7 → 2.
- DIVU 5÷0 → 0xFFFFFFFF and REMU 5÷0 → 5, each with `done` at cycle 2. DIV 0x80000000÷0xFFFFFFFF → 0x80000000.
- `start` pulsed while `busy` → ignored; only one `done`. Next `start` the cycle after `done` → accepted.
- `rst` at cycle 10 of a MUL → `busy`=0 and `result`=0 the next cycle, no `done`. Without `RV_MULDIV_DIV_EN`: DIV → `result`=0, `done` at cycle 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared definitions for the RV32M multiply/divide sequencer.
//   XLEN             : default datapath width.
//   MULDIV_*         : funct3 encodings of the M-extension operations.
//   muldiv_state_t   : sequencer FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step -- one combinational iteration of the multiply/divide loop.
//   div_i  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i  : 2*XLEN accumulator {hi, lo} before the step
//   m_i    : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o  : accumulator after the step
// Multiply: lo holds the remaining multiplier bits; hi accumulates and the
// whole pair shifts right, so after XLEN steps {hi, lo} is the product.
// Divide: {rem, dividend} shifts left; a quotient bit enters lo[0] and the
// remainder is kept in hi.
// Build option: RV_MULDIV_DIV_EN enables the divide step; without it only
// the multiply step exists and div_i is ignored.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   m_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;

`ifdef RV_MULDIV_DIV_EN
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            unused_dbit;

  // A successful trial subtract leaves diff < m_i, so bit XLEN is always 0.
  assign unused_dbit = diff[XLEN];
`else
  logic unused_div;

  assign unused_div = div_i;
`endif

  always_comb begin
    // The carry out of the add becomes the new top bit after the shift.
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : '0);
    acc_o = {sum, acc_i[XLEN-1:1]};
`ifdef RV_MULDIV_DIV_EN
    // Shifted partial remainder needs XLEN+1 bits; the extra diff bit is
    // the borrow of the trial subtract.
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = {1'b0, rem_sh} - {2'b00, m_i};
    if (div_i) begin
      if (diff[XLEN+1]) begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative RV32M multiply/divide sequencer.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, aborts any operation
//   start  : request an operation, sampled only in IDLE
//   op     : funct3 of the M instruction
//   rs1    : multiplicand / dividend
//   rs2    : multiplier / divisor
//   busy   : high from the cycle after acceptance through the done cycle
//   done   : one-cycle pulse, result valid in the same cycle
//   result : registered result, held until the next accepted start
// Operands are reduced to magnitudes at acceptance; the loop works on
// unsigned values and FIX restores the sign.
// Build option: RV_MULDIV_DIV_EN enables DIV/DIVU/REM/REMU. Without it any
// op[2]=1 request completes in one cycle with result 0.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  muldiv_state_t     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              signed_a, signed_b;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] step_acc;
  logic              step_div;

`ifdef RV_MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] quo, rem;
  logic            ovf;
`endif

  assign step_div = (state_q == MD_DIV);

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .div_i(step_div),
    .acc_i(acc_q),
    .m_i  (m_q),
    .acc_o(step_acc)
  );

  // Operand magnitudes and sign flags for the acceptance cycle.
  always_comb begin
    signed_a = (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
               (op == MULDIV_DIV)  || (op == MULDIV_REM);
    signed_b = (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
    a_neg    = signed_a & rs1[XLEN-1];
    b_neg    = signed_b & rs2[XLEN-1];
    abs_a    = a_neg ? ('0 - rs1) : rs1;
    abs_b    = b_neg ? ('0 - rs2) : rs2;
  end

  // Sign correction of the finished accumulator.
  always_comb begin
    prod = neg_q ? ('0 - acc_q) : acc_q;
`ifdef RV_MULDIV_DIV_EN
    quo  = neg_q  ? ('0 - acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
    rem  = rneg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    ovf  = !op[0] && (rs1 == MOST_NEG) && (rs2 == '1);
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
`ifdef RV_MULDIV_DIV_EN
    rneg_d   = rneg_q;
`endif

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          neg_d = a_neg ^ b_neg;
          if (!op[2]) begin
            m_d     = abs_a;
            acc_d   = {{XLEN{1'b0}}, abs_b};
            state_d = MD_MUL;
          end else begin
`ifdef RV_MULDIV_DIV_EN
            m_d    = abs_b;
            rneg_d = a_neg;
            // Special cases preload the final raw {rem, quo} with signs
            // cleared, so FIX passes them through unchanged.
            if (rs2 == '0) begin
              acc_d   = {rs1, {XLEN{1'b1}}};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = MD_FIX;
            end else if (ovf) begin
              acc_d   = {{XLEN{1'b0}}, MOST_NEG};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = MD_FIX;
            end else begin
              acc_d   = {{XLEN{1'b0}}, abs_a};
              state_d = MD_DIV;
            end
`else
            result_d = '0;
            state_d  = MD_DONE;
`endif
          end
        end
      end
      MD_MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = MD_FIX;
      end
`ifdef RV_MULDIV_DIV_EN
      MD_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = MD_FIX;
      end
`endif
      MD_FIX: begin
        case (op_q)
          MULDIV_MUL:    result_d = prod[XLEN-1:0];
          MULDIV_MULH,
          MULDIV_MULHSU,
          MULDIV_MULHU:  result_d = prod[2*XLEN-1:XLEN];
`ifdef RV_MULDIV_DIV_EN
          MULDIV_DIV,
          MULDIV_DIVU:   result_d = quo;
          MULDIV_REM,
          MULDIV_REMU:   result_d = rem;
`endif
          default:       result_d = '0;
        endcase
        state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
`ifdef RV_MULDIV_DIV_EN
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
`ifdef RV_MULDIV_DIV_EN
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy   = (state_q != MD_IDLE);
  assign done   = (state_q == MD_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed self-checking bench for muldiv_seq (XLEN=32).
// Latencies are counted in falling edges after the edge that accepts start,
// so the k-th observation shows the state of cycle k.
// Divide expectations follow RV_MULDIV_DIV_EN.
module tb_muldiv_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

`ifdef RV_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam int LAT_ITER = 34;

  always #5 clk = ~clk;

  muldiv_seq #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  // Launch one operation and wait (bounded) for done; lat=0 means timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    res = '0;
    lat = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom()); rs1 = $urandom(); rs2 = $urandom();
    for (int unsigned k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = int'(k);
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 00000000", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0]  vo[4];
    logic [31:0] va[4], vb[4], ve[4];
    logic [31:0] res;
    int          lat;
    vo = '{MULDIV_MUL, MULDIV_MULH, MULDIV_MULHU, MULDIV_MULHSU};
    va = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    ve = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int unsigned i = 0; i < 4; i++) begin
      run_op(vo[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin
        errors++; $display("FAIL mul[%0d] result: got %h want %h", i, res, ve[i]);
      end
      checks++;
      if (lat != LAT_ITER) begin
        errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, LAT_ITER);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  vo[6];
    logic [31:0] va[6], vb[6], ve[6];
    logic [31:0] res;
    int          lat;
    vo = '{MULDIV_DIV, MULDIV_REM, MULDIV_DIVU, MULDIV_REMU, MULDIV_DIV, MULDIV_REM};
    va = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    vb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    ve = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    for (int unsigned i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== (DIV_EN ? ve[i] : 32'h0)) begin
        errors++; $display("FAIL div[%0d] result: got %h want %h", i, res, DIV_EN ? ve[i] : 32'h0);
      end
      checks++;
      if (lat != (DIV_EN ? LAT_ITER : 1)) begin
        errors++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, DIV_EN ? LAT_ITER : 1);
      end
    end
  endtask

  task automatic test_div_special;
    logic [2:0]  vo[5];
    logic [31:0] va[5], vb[5], ve[5];
    logic [31:0] res;
    int          lat;
    vo = '{MULDIV_DIVU, MULDIV_REMU, MULDIV_DIV, MULDIV_REM, MULDIV_REM};
    va = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    vb = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    ve = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFF9};
    for (int unsigned i = 0; i < 5; i++) begin
      run_op(vo[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== (DIV_EN ? ve[i] : 32'h0)) begin
        errors++; $display("FAIL divspec[%0d] result: got %h want %h", i, res, DIV_EN ? ve[i] : 32'h0);
      end
      checks++;
      if (lat != (DIV_EN ? 2 : 1)) begin
        errors++; $display("FAIL divspec[%0d] latency: got %0d want %0d", i, lat, DIV_EN ? 2 : 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    int          ndone = 0;
    int          first = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    start = 1'b1; op = MULDIV_MUL; rs1 = 32'd7; rs2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int unsigned k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin first = int'(k); res = result; end
      end
      if (k == 5) begin
        start = 1'b1; op = MULDIV_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore done count: got %0d want 1", ndone); end
    checks++; if (first != LAT_ITER) begin errors++; $display("FAIL ignore latency: got %0d want %0d", first, LAT_ITER); end
    checks++; if (res !== 32'd21) begin errors++; $display("FAIL ignore result: got %h want 00000015", res); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int          lat = 0;
    run_op(MULDIV_MUL, 32'd6, 32'd7, res, lat);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL b2b first result: got %h want 0000002a", res); end
    // start raised during the done cycle: ignored there, accepted one cycle later
    start = 1'b1; op = MULDIV_MUL; rs1 = 32'd5; rs2 = 32'd9;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b idle busy: got %b want 0", busy); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b accept busy: got %b want 1", busy); end
    lat = 0;
    for (int unsigned k = 2; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = int'(k); res = result; break; end
    end
    checks++; if (lat != LAT_ITER) begin errors++; $display("FAIL b2b latency: got %0d want %0d", lat, LAT_ITER); end
    checks++; if (res !== 32'd45) begin errors++; $display("FAIL b2b result: got %h want 0000002d", res); end
  endtask

  task automatic test_abort;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = MULDIV_MUL; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort pre busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort result: got %h want 00000000", result); end
    for (int unsigned k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort activity: got %0d cycles want 0", ndone); end
    // reset wins over a simultaneous start
    start = 1'b1; rst = 1'b1; op = MULDIV_MUL; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
